// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order allocation at the tail, out-of-order writeback,
// in-order retirement from the head, with a flush on a mispredicted branch.
// Optional feature macro: ROB_WB_BYPASS_EN. When it is defined, a writeback to
// a pending head entry becomes visible on the commit port in the same cycle.
module reorder_buffer #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 16,
    parameter int REG_W  = 4,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              alloc_valid,
    input  logic [REG_W-1:0]  alloc_rd,
    input  logic              alloc_is_branch,
    output logic              alloc_ready,
    output logic [IDX_W-1:0]  alloc_tag,
    input  logic              wb_valid,
    input  logic [IDX_W-1:0]  wb_tag,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              wb_mispredict,
    output logic              commit_valid,
    input  logic              commit_ready,
    output logic [REG_W-1:0]  commit_rd,
    output logic [DATA_W-1:0] commit_data,
    output logic [IDX_W-1:0]  commit_tag,
    output logic              flush,
    output logic [IDX_W:0]    count
);

    typedef enum logic [1:0] {FREE, PEND, DONE} ent_state_t;

    localparam logic [IDX_W:0]   CNT_FULL = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0] PTR_ONE  = IDX_W'(1);

    ent_state_t        st     [DEPTH];
    logic [REG_W-1:0]  rd_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic              br_q   [DEPTH];
    logic              mp_q   [DEPTH];

    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;

    logic alloc_acc;
    logic wb_hit;
    logic byp;
    logic head_mp;
    logic retire;
    logic flush_now;

    // Only a pending entry accepts a writeback; later writebacks to it are dropped.
    assign wb_hit = wb_valid && (st[wb_tag] == PEND);

`ifdef ROB_WB_BYPASS_EN
    assign byp = wb_hit && (wb_tag == head);
`else
    assign byp = 1'b0;
`endif

    assign alloc_ready  = (count != CNT_FULL);
    assign alloc_tag    = tail;
    assign alloc_acc    = alloc_valid && alloc_ready;

    assign commit_valid = (st[head] == DONE) || byp;
    assign commit_rd    = rd_q[head];
    assign commit_data  = byp ? wb_data : data_q[head];
    assign commit_tag   = head;
    assign head_mp      = byp ? (wb_mispredict && br_q[head]) : mp_q[head];

    assign retire       = commit_valid && commit_ready;
    assign flush_now    = retire && head_mp;

    // Entry payload: no reset needed, every field is qualified by its entry state.
    always_ff @(posedge clk1) begin
        if (alloc_acc) begin
            rd_q[tail] <= alloc_rd;
            br_q[tail] <= alloc_is_branch;
        end
        if (wb_hit) begin
            data_q[wb_tag] <= wb_data;
            mp_q[wb_tag]   <= wb_mispredict && br_q[wb_tag];
        end
    end

    // Entry states, pointers, occupancy and the flush pulse.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) st[i] <= FREE;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            flush <= 1'b0;
        end else begin
            flush <= flush_now;
            if (flush_now) begin
                // Mispredicted branch retired: drop everything younger,
                // including any allocation or writeback seen this cycle.
                for (int i = 0; i < DEPTH; i++) st[i] <= FREE;
                head  <= head + PTR_ONE;
                tail  <= head + PTR_ONE;
                count <= '0;
            end else begin
                // Writeback first so a bypassed retirement of the same entry wins.
                if (wb_hit) st[wb_tag] <= DONE;
                if (retire) begin
                    st[head] <= FREE;
                    head     <= head + PTR_ONE;
                end
                if (alloc_acc) begin
                    st[tail] <= PEND;
                    tail     <= tail + PTR_ONE;
                end
                case ({alloc_acc, retire})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a DEPTH=8 instance for most scenarios
// and a DEPTH=4 instance for the pointer-wrap run.
module tb_reorder_buffer;

    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    logic rst_n;

    logic        a_alloc_valid, a_alloc_is_branch, a_alloc_ready;
    logic [3:0]  a_alloc_rd;
    logic [2:0]  a_alloc_tag;
    logic        a_wb_valid, a_wb_mispredict;
    logic [2:0]  a_wb_tag;
    logic [15:0] a_wb_data;
    logic        a_commit_valid, a_commit_ready;
    logic [3:0]  a_commit_rd;
    logic [15:0] a_commit_data;
    logic [2:0]  a_commit_tag;
    logic        a_flush;
    logic [3:0]  a_count;

    logic        b_alloc_valid, b_alloc_is_branch, b_alloc_ready;
    logic [3:0]  b_alloc_rd;
    logic [1:0]  b_alloc_tag;
    logic        b_wb_valid, b_wb_mispredict;
    logic [1:0]  b_wb_tag;
    logic [15:0] b_wb_data;
    logic        b_commit_valid, b_commit_ready;
    logic [3:0]  b_commit_rd;
    logic [15:0] b_commit_data;
    logic [1:0]  b_commit_tag;
    logic        b_flush;
    logic [2:0]  b_count;

    int checks = 0;
    int errors = 0;
    int exp_ret;

    reorder_buffer #(.DEPTH(8), .DATA_W(16), .REG_W(4)) u8 (
        .clk1(clk1), .rst_n(rst_n),
        .alloc_valid(a_alloc_valid), .alloc_rd(a_alloc_rd), .alloc_is_branch(a_alloc_is_branch),
        .alloc_ready(a_alloc_ready), .alloc_tag(a_alloc_tag),
        .wb_valid(a_wb_valid), .wb_tag(a_wb_tag), .wb_data(a_wb_data), .wb_mispredict(a_wb_mispredict),
        .commit_valid(a_commit_valid), .commit_ready(a_commit_ready), .commit_rd(a_commit_rd),
        .commit_data(a_commit_data), .commit_tag(a_commit_tag), .flush(a_flush), .count(a_count)
    );

    reorder_buffer #(.DEPTH(4), .DATA_W(16), .REG_W(4)) u4 (
        .clk1(clk1), .rst_n(rst_n),
        .alloc_valid(b_alloc_valid), .alloc_rd(b_alloc_rd), .alloc_is_branch(b_alloc_is_branch),
        .alloc_ready(b_alloc_ready), .alloc_tag(b_alloc_tag),
        .wb_valid(b_wb_valid), .wb_tag(b_wb_tag), .wb_data(b_wb_data), .wb_mispredict(b_wb_mispredict),
        .commit_valid(b_commit_valid), .commit_ready(b_commit_ready), .commit_rd(b_commit_rd),
        .commit_data(b_commit_data), .commit_tag(b_commit_tag), .flush(b_flush), .count(b_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic a_idle();
        a_alloc_valid = 0; a_alloc_rd = 0; a_alloc_is_branch = 0;
        a_wb_valid = 0; a_wb_tag = 0; a_wb_data = 0; a_wb_mispredict = 0;
        a_commit_ready = 0;
    endtask

    task automatic b_idle();
        b_alloc_valid = 0; b_alloc_rd = 0; b_alloc_is_branch = 0;
        b_wb_valid = 0; b_wb_tag = 0; b_wb_data = 0; b_wb_mispredict = 0;
        b_commit_ready = 0;
    endtask

    task automatic a_wb(input logic [2:0] tag, input logic [15:0] data, input logic mp);
        a_wb_valid = 1; a_wb_tag = tag; a_wb_data = data; a_wb_mispredict = mp;
    endtask

    task automatic a_fill(input int n, input int br_tag);
        for (int i = 0; i < n; i++) begin
            a_alloc_valid = 1;
            a_alloc_rd = 4'(i);
            a_alloc_is_branch = (i == br_tag);
            tick();
        end
        a_alloc_valid = 0;
        a_alloc_is_branch = 0;
    endtask

    task automatic pulse_reset();
        rst_n = 0;
        #1;
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        a_idle();
        b_idle();
        #2;
        chk("rst_alloc_ready", 32'(a_alloc_ready), 1);
        chk("rst_alloc_tag", 32'(a_alloc_tag), 0);
        chk("rst_commit_valid", 32'(a_commit_valid), 0);
        chk("rst_count", 32'(a_count), 0);
        chk("rst_flush", 32'(a_flush), 0);
        tick();
        tick();
        rst_n = 1;

        // Fill all eight entries back to back, then try a ninth.
        for (int i = 0; i < 8; i++) begin
            a_alloc_valid = 1;
            a_alloc_rd = 4'(i);
            #1;
            chk("fill_tag", 32'(a_alloc_tag), 32'(i));
            tick();
        end
        a_alloc_valid = 0;
        #1;
        chk("full_count", 32'(a_count), 8);
        chk("full_ready", 32'(a_alloc_ready), 0);
        a_alloc_valid = 1;
        tick();
        a_alloc_valid = 0;
        #1;
        chk("ninth_count", 32'(a_count), 8);
        chk("ninth_tail", 32'(a_alloc_tag), 0);

        // Out-of-order writeback 2,0,1; retirement must be 0,1,2.
        a_wb(3'd2, 16'h0022, 0); tick();
        a_wb(3'd0, 16'h0000, 0); tick();
        a_wb(3'd1, 16'h0011, 0); tick();
        a_wb_valid = 0;
        a_commit_ready = 1;
        #1;
        chk("ret0_valid", 32'(a_commit_valid), 1);
        chk("ret0_tag", 32'(a_commit_tag), 0);
        chk("ret0_data", 32'(a_commit_data), 32'h0000);
        tick();
        chk("ret1_tag", 32'(a_commit_tag), 1);
        chk("ret1_data", 32'(a_commit_data), 32'h0011);
        chk("ret1_rd", 32'(a_commit_rd), 1);
        tick();
        chk("ret2_tag", 32'(a_commit_tag), 2);
        chk("ret2_data", 32'(a_commit_data), 32'h0022);
        tick();
        chk("ret_done_valid", 32'(a_commit_valid), 0);
        chk("ret_done_count", 32'(a_count), 5);
        a_commit_ready = 0;

        // Asynchronous reset between edges clears everything at once.
        rst_n = 0;
        #1;
        chk("async_count", 32'(a_count), 0);
        chk("async_head", 32'(a_commit_tag), 0);
        chk("async_ready", 32'(a_alloc_ready), 1);
        tick();
        rst_n = 1;

        // Mispredicted branch at tag 1 with 2..4 still pending.
        a_fill(5, 1);
        a_wb(3'd1, 16'h0bad, 1); tick();
        a_wb(3'd0, 16'h0005, 0); tick();
        a_wb_valid = 0;
        a_commit_ready = 1;
        #1;
        chk("br_ret0_tag", 32'(a_commit_tag), 0);
        tick();
        chk("br_ret1_tag", 32'(a_commit_tag), 1);
        chk("br_ret1_valid", 32'(a_commit_valid), 1);
        chk("br_pre_flush", 32'(a_flush), 0);
        a_alloc_valid = 1;
        a_alloc_rd = 4'd9;
        a_wb(3'd2, 16'h1234, 0);
        tick();
        a_alloc_valid = 0;
        a_wb_valid = 0;
        chk("flush_pulse", 32'(a_flush), 1);
        chk("flush_count", 32'(a_count), 0);
        chk("flush_commit_valid", 32'(a_commit_valid), 0);
        chk("flush_next_tag", 32'(a_alloc_tag), 2);
        chk("flush_ready", 32'(a_alloc_ready), 1);
        tick();
        chk("flush_one_cycle", 32'(a_flush), 0);
        chk("flush_head_free", 32'(a_commit_valid), 0);
        a_commit_ready = 0;

        // Full ROB: retirement and allocation together; allocation refused.
        pulse_reset();
        a_fill(8, -1);
        a_wb(3'd0, 16'h0077, 0); tick();
        a_wb_valid = 0;
        a_commit_ready = 1;
        a_alloc_valid = 1;
        #1;
        chk("fullret_ready", 32'(a_alloc_ready), 0);
        chk("fullret_cvalid", 32'(a_commit_valid), 1);
        tick();
        a_alloc_valid = 0;
        a_commit_ready = 0;
        chk("fullret_count", 32'(a_count), 7);
        chk("fullret_ready_next", 32'(a_alloc_ready), 1);
        chk("fullret_tail", 32'(a_alloc_tag), 0);

        // Writeback to the pending head with commit_ready high.
        pulse_reset();
        a_alloc_valid = 1;
        a_alloc_rd = 4'd3;
        tick();
        a_alloc_valid = 0;
        a_wb(3'd0, 16'h0041, 0);
        a_commit_ready = 1;
        #1;
`ifdef ROB_WB_BYPASS_EN
        chk("byp_valid", 32'(a_commit_valid), 1);
        chk("byp_data", 32'(a_commit_data), 32'h0041);
        chk("byp_rd", 32'(a_commit_rd), 3);
        tick();
        a_wb_valid = 0;
        chk("byp_count", 32'(a_count), 0);
        chk("byp_after_valid", 32'(a_commit_valid), 0);
`else
        chk("nobyp_valid", 32'(a_commit_valid), 0);
        tick();
        a_wb_valid = 0;
        chk("nobyp_valid_next", 32'(a_commit_valid), 1);
        chk("nobyp_data", 32'(a_commit_data), 32'h0041);
        chk("nobyp_rd", 32'(a_commit_rd), 3);
        tick();
        chk("nobyp_count", 32'(a_count), 0);
`endif
        a_commit_ready = 0;

        // DEPTH=4: twenty alloc/writeback/commit cycles across the wrap.
        pulse_reset();
        exp_ret = 0;
        for (int k = 0; k < 20; k++) begin
            b_alloc_valid = 1;
            b_alloc_rd = 4'(k);
            b_commit_ready = 1;
            if (k > 0) begin
                b_wb_valid = 1;
                b_wb_tag = 2'((k - 1) % 4);
                b_wb_data = 16'(k);
            end
            #1;
            chk("wrap_alloc_tag", 32'(b_alloc_tag), 32'(k % 4));
            chk("wrap_count_max", 32'(b_count <= 3'd4), 1);
            if (b_commit_valid) begin
                chk("wrap_commit_tag", 32'(b_commit_tag), 32'(exp_ret % 4));
                exp_ret++;
            end
            tick();
        end
        b_alloc_valid = 0;
        b_wb_valid = 1;
        b_wb_tag = 2'd3;
        #1;
        if (b_commit_valid) begin
            chk("wrap_commit_tag", 32'(b_commit_tag), 32'(exp_ret % 4));
            exp_ret++;
        end
        tick();
        b_wb_valid = 0;
        for (int n = 0; n < 10 && exp_ret < 20; n++) begin
            #1;
            if (b_commit_valid) begin
                chk("wrap_commit_tag", 32'(b_commit_tag), 32'(exp_ret % 4));
                exp_ret++;
            end
            tick();
        end
        chk("wrap_retired_total", 32'(exp_ret), 20);
        chk("wrap_final_count", 32'(b_count), 0);
        b_commit_ready = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
